// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl -- SPI host for a simple 7-bit-address byte memory.
//
// Each transaction sends one 16-bit frame {addr[6:0], rw, data[7:0]}, MSB
// first, using SPI mode 0 timing. For reads the data byte is sent as zeros,
// and miso is captured during SCLK periods 9..16.
//
// Ports
//   clk       system clock (single clock domain)
//   reset     synchronous, active-high reset
//   req       transaction request; accepted only while idle
//   rw        1 = read, 0 = write (latched at accept)
//   addr      7-bit memory address (latched at accept)
//   wdata     write data byte (latched at accept)
//   busy      high from accept through the done cycle
//   done      one-cycle completion pulse
//   rdata     result of the most recent completed read
//   sclk_pin  SPI serial clock (idles low)
//   cs_pin    SPI chip select, active low
//   mosi_pin  serial data to the memory
//   miso_pin  serial data from the memory
module spi_host_ctrl #(
  parameter int HALF_PERIOD = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t      state;
  logic [PW-1:0] phase;
  logic [4:0]  bit_cnt;   // completed SCLK periods, 0..16
  logic [15:0] tx_sh;
  logic [7:0]  rx_sh;
  logic        rw_q;
  logic        phase_end;

  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rw_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 8'h00;
      sclk_pin <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          sclk_pin <= 1'b0;
          phase    <= '0;
          bit_cnt  <= '0;
          if (req) begin
            // Read frames carry zeros in the data byte.
            tx_sh    <= {addr, rw, (rw ? 8'h00 : wdata)};
            mosi_pin <= addr[6];
            rw_q     <= rw;
            busy     <= 1'b1;
            cs_pin   <= 1'b0;
            state    <= SETUP;
          end else begin
            busy     <= 1'b0;
            cs_pin   <= 1'b1;
            mosi_pin <= 1'b0;
          end
        end

        SETUP: begin
          if (phase_end) begin
            phase    <= '0;
            sclk_pin <= 1'b1;
            state    <= SHIFT;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        // Each period is a high half then a low half; the low half of the
        // 16th period is still spent here before moving on to HOLD.
        SHIFT: begin
          if (!phase_end) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            if (sclk_pin) begin
              sclk_pin <= 1'b0;
              tx_sh    <= {tx_sh[14:0], 1'b0};
              mosi_pin <= tx_sh[14];
              bit_cnt  <= bit_cnt + 5'd1;
            end else if (bit_cnt == 5'd16) begin
              state <= HOLD;
            end else begin
              sclk_pin <= 1'b1;
              // bit_cnt 8..15 here means this rise opens period 9..16.
              if (rw_q && (bit_cnt >= 5'd8)) begin
                rx_sh <= {rx_sh[6:0], miso_pin};
              end
            end
          end
        end

        HOLD: begin
          if (phase_end) begin
            phase  <= '0;
            cs_pin <= 1'b1;
            done   <= 1'b1;
            if (rw_q) begin
              rdata <= rx_sh;
            end
            state <= DONE;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
